// File: rtl/hier_path_serializer.sv
// hier_path_serializer: turns a flat leaf index into a stream of base-FANOUT digits, level 0 (MSB) first.
// Define HIER_PATH_SERIALIZER_RANGE_CHECK_EN to reject indices >= FANOUT**DEPTH with an err pulse.
module hier_path_serializer #(
    parameter int unsigned FANOUT = 5,
    parameter int unsigned DEPTH  = 9,
    parameter int unsigned IDX_W  = 21,
    parameter int unsigned DIG_W  = 3,
    localparam int unsigned LVL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DIG_W-1:0] out_digit,
    output logic [LVL_W-1:0] out_level,
    output logic             out_last,
    output logic             err
);

    localparam logic [LVL_W-1:0] LAST_LVL   = LVL_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] FANOUT_IDX = IDX_W'(FANOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] work, work_next;
    logic [LVL_W-1:0] cnt, cnt_next;
    logic [LVL_W-1:0] ptr, ptr_next;
    logic [DIG_W-1:0] dbuf [DEPTH];

    logic             conv_we_c;
    logic [LVL_W-1:0] slot_c;
    logic [DIG_W-1:0] rem_c;
    logic             range_bad_c;

    logic             in_ready_next;
    logic             out_valid_next;
    logic [DIG_W-1:0] out_digit_next;
    logic [LVL_W-1:0] out_level_next;
    logic             out_last_next;
    logic             err_next;

`ifdef HIER_PATH_SERIALIZER_RANGE_CHECK_EN
    function automatic logic [63:0] pow_f(input int unsigned base, input int unsigned exp);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < exp; i++) begin
            r = r * 64'(base);
        end
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow_f(FANOUT, DEPTH);

    assign range_bad_c = (64'(in_index) >= LIMIT);
`else
    // Out-of-range indices wrap naturally: only DEPTH digits are ever extracted.
    assign range_bad_c = 1'b0;
`endif

    // Next-state, datapath and registered-output selection
    always_comb begin
        state_next     = state;
        work_next      = work;
        cnt_next       = cnt;
        ptr_next       = ptr;
        conv_we_c      = 1'b0;
        err_next       = 1'b0;
        rem_c          = DIG_W'(work % FANOUT_IDX);
        slot_c         = LAST_LVL - cnt;
        in_ready_next  = 1'b0;
        out_valid_next = 1'b0;
        out_digit_next = '0;
        out_level_next = '0;
        out_last_next  = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (range_bad_c) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = CONV;
                        work_next  = in_index;
                        cnt_next   = '0;
                    end
                end
            end
            CONV: begin
                conv_we_c = 1'b1;
                work_next = work / FANOUT_IDX;
                cnt_next  = cnt + LVL_W'(1);
                if (cnt == LAST_LVL) begin
                    state_next = EMIT;
                    cnt_next   = '0;
                    ptr_next   = '0;
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    if (ptr == LAST_LVL) begin
                        state_next = IDLE;
                        ptr_next   = '0;
                    end else begin
                        ptr_next = ptr + LVL_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == EMIT);
        if (state_next == EMIT) begin
            // Slot 0 is written on the last CONV edge, so bypass its digit for the first beat.
            out_digit_next = (state == CONV) ? rem_c : dbuf[ptr_next];
            out_level_next = ptr_next;
            out_last_next  = (ptr_next == LAST_LVL);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            ptr       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_digit <= '0;
            out_level <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dbuf[i] <= '0;
            end
        end else begin
            state     <= state_next;
            work      <= work_next;
            cnt       <= cnt_next;
            ptr       <= ptr_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
            out_digit <= out_digit_next;
            out_level <= out_level_next;
            out_last  <= out_last_next;
            err       <= err_next;
            if (conv_we_c) begin
                dbuf[slot_c] <= rem_c;
            end
        end
    end

endmodule

// File: tb/tb_hier_path_serializer.sv
// Self-checking bench for hier_path_serializer: scoreboard of expected digit beats per accepted index.
module tb_hier_path_serializer;

    localparam int unsigned FANOUT = 5;
    localparam int unsigned DEPTH  = 9;
    localparam int unsigned IDX_W  = 21;
    localparam int unsigned DIG_W  = 3;
    localparam int unsigned LVL_W  = 4;
    localparam int unsigned LIMIT  = FANOUT ** DEPTH;

    typedef struct packed {
        logic [DIG_W-1:0] digit;
        logic [LVL_W-1:0] level;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IDX_W-1:0] in_index = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [DIG_W-1:0] out_digit;
    logic [LVL_W-1:0] out_level;
    logic             out_last;
    logic             err;

    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    err_cyc = -1;
    bit    expect_first = 1'b0;
    beat_t q[$];

    hier_path_serializer #(
        .FANOUT(FANOUT),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .DIG_W (DIG_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_index (in_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_digit(out_digit),
        .out_level(out_level),
        .out_last (out_last),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: base-FANOUT digits, MSB at level 0, modulo FANOUT**DEPTH.
    task automatic push_expected(input logic [IDX_W-1:0] idx);
        int unsigned v;
        int unsigned d [DEPTH];
`ifdef HIER_PATH_SERIALIZER_RANGE_CHECK_EN
        if (32'(idx) >= LIMIT) begin
            err_cyc = cyc + 1;
            return;
        end
`endif
        v = 32'(idx);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            d[k] = v % FANOUT;
            v    = v / FANOUT;
        end
        for (int k = 0; k < DEPTH; k++) begin
            q.push_back('{digit: DIG_W'(d[k]), level: LVL_W'(k), last: (k == DEPTH - 1)});
        end
        acc_cyc      = cyc;
        expect_first = 1'b1;
    endtask

    // Monitor: compare every visible beat against the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            check("err", 32'(err), 32'(cyc == err_cyc));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_beat", 32'(out_valid), 32'(0));
                end else begin
                    check("digit", 32'(out_digit), 32'(q[0].digit));
                    check("level", 32'(out_level), 32'(q[0].level));
                    check("last", 32'(out_last), 32'(q[0].last));
                    if (expect_first) begin
                        check("first_beat_latency", 32'(cyc - acc_cyc), 32'(DEPTH + 1));
                        expect_first = 1'b0;
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) push_expected(in_index);
        end
    end

    task automatic wait_ready(output int c);
        bit ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
        check("accept_timeout", 32'(ok), 32'(1));
    endtask

    task automatic send(input logic [IDX_W-1:0] idx);
        int c;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_index = idx;
        wait_ready(c);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_index = ~idx;
    endtask

    task automatic drain(input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        check("drain_timeout", 32'(ok), 32'(1));
    endtask

    task automatic wait_level(input int lvl);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid && 32'(out_level) == lvl) begin
                ok = 1'b1;
                break;
            end
        end
        check("level_timeout", 32'(ok), 32'(1));
    endtask

    initial begin
        int          c1;
        int          c2;
        logic [31:0] exp_ready;
        logic [IDX_W-1:0] idx;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_digit", 32'(out_digit), 32'(0));
        check("rst_out_level", 32'(out_level), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // All-zero and all-max paths
        send(IDX_W'(0));
        drain(1'b0);
        send(IDX_W'(1953124));
        drain(1'b0);

        // Backpressure hold on level 7 of index 13 (digit 2)
        send(IDX_W'(13));
        wait_level(6);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_level", 32'(out_level), 32'(7));
            check("hold_digit", 32'(out_digit), 32'(2));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(1'b0);

        // Reset in the middle of EMIT
        send(IDX_W'(100));
        wait_level(4);
        #1;
        rst_n = 1'b0;
        q.delete();
        expect_first = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_out_valid2", 32'(out_valid), 32'(0));
        repeat (15) @(negedge clk);

        // Out-of-range index
`ifdef HIER_PATH_SERIALIZER_RANGE_CHECK_EN
        exp_ready = 32'(1);
`else
        exp_ready = 32'(0);
`endif
        send(IDX_W'(LIMIT));
        @(negedge clk);
        check("range_in_ready", 32'(in_ready), exp_ready);
        drain(1'b0);
        send(IDX_W'(2097151));
        drain(1'b0);

        // Back-to-back with in_valid held high
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_index = IDX_W'(7);
        wait_ready(c1);
        @(posedge clk);
        #1;
        in_index = IDX_W'(8);
        wait_ready(c2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_gap", 32'(c2 - c1), 32'(2 * DEPTH + 1));
        drain(1'b0);

        // Random indices under random backpressure
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 3) idx = IDX_W'($urandom_range(LIMIT, (1 << IDX_W) - 1));
            else            idx = IDX_W'($urandom_range(0, LIMIT - 1));
            send(idx);
            drain(1'b1);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hier_path_serializer.md
HIER_PATH_SERIALIZER -- requirements
Module: hier_path_serializer

Interface
REQ-001 The block SHALL have parameter FANOUT, default 5, children per hierarchy node.
REQ-002 The block SHALL have parameter DEPTH, default 9, hierarchy levels below root.
REQ-003 The block SHALL have parameter IDX_W, default 21, flat leaf-index width, at least ceil(log2(FANOUT^DEPTH)).
REQ-004 The block SHALL have parameter DIG_W, default 3, digit width, ceil(log2(FANOUT)).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, flat index offered.
REQ-008 The block SHALL have port in_ready, output, 1, index accepted when high with in_valid.
REQ-009 The block SHALL have port in_index, input, IDX_W, flat leaf index.
REQ-010 The block SHALL have port out_valid, output, 1, digit beat valid.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts beat.
REQ-012 The block SHALL have port out_digit, output, DIG_W, child select at this level.
REQ-013 The block SHALL have port out_level, output, ceil(log2(DEPTH)), level number of the beat, 0 = nearest root.
REQ-014 The block SHALL have port out_last, output, 1, high on the level DEPTH-1 beat.
REQ-015 The block SHALL have port err, output, 1, single-cycle out-of-range pulse (see REQ-029).

Function
REQ-016 The block SHALL implement FSM states IDLE, CONV and EMIT.
REQ-017 in_ready SHALL be high only in IDLE; accept occurs on the cycle in_valid && in_ready, capturing in_index into a working register.
REQ-018 On accept, the FSM SHALL go from IDLE to CONV.
REQ-019 CONV SHALL last exactly DEPTH cycles; each cycle it stores work % FANOUT into digit buffer slot DEPTH-1-k (k = cycle count from 0) and sets work = work / FANOUT.
REQ-020 After the DEPTH-th CONV cycle, the FSM SHALL enter EMIT with beat pointer 0.
REQ-021 In EMIT, out_valid SHALL be high; out_digit = buffer[pointer], out_level = pointer, out_last = (pointer == DEPTH-1).
REQ-022 A beat SHALL transfer on out_valid && out_ready; pointer increments by one.
REQ-023 Under out_ready low, out_digit, out_level and out_last SHALL stay stable.
REQ-024 On transfer of the out_last beat, the FSM SHALL return to IDLE; in_ready is high the next cycle; there are no bubbles inside EMIT.
REQ-025 Minimum accept-to-first-beat latency SHALL be DEPTH+1 cycles; with out_ready constantly high, a full path SHALL take 2*DEPTH+1 cycles from accept to the next in_ready.
REQ-026 Digits SHALL be equivalent to base-FANOUT representation, MSB at level 0.
REQ-027 in_valid SHALL be ignored outside IDLE; in_index is sampled only at accept.

Reset
REQ-028 When rst_n is low at a clock edge, the block SHALL enter IDLE and clear the work register, digit buffer and pointer; outputs SHALL be in_ready=1 (after reset release), out_valid=0, out_digit=0, out_level=0, out_last=0, err=0; reset mid-CONV or mid-EMIT SHALL discard the path with no further beats.

Configuration
REQ-029 With macro HIER_PATH_SERIALIZER_RANGE_CHECK_EN defined, an accepted index >= FANOUT^DEPTH SHALL cause a one-cycle err pulse on the cycle after accept, no CONV/EMIT, and a return to IDLE with in_ready high that cycle.
REQ-030 Without HIER_PATH_SERIALIZER_RANGE_CHECK_EN, err SHALL be tied 0 and out-of-range indices SHALL be serialized modulo FANOUT^DEPTH.

Verification
REQ-031 Accept index 0, out_ready=1 -> nine beats of digit 0, levels 0..8, out_last only on level 8, first beat 10 cycles after accept.
REQ-032 Accept index 1953124 -> nine beats of digit 4.
REQ-033 Accept index 13 -> digits 0,0,0,0,0,0,0,2,3; hold out_ready low 3 cycles on level 7 -> beat 7 held stable, digit 2.
REQ-034 Drive rst_n low during EMIT at level 4 -> out_valid=0 next cycle, IDLE, in_ready=1 after release, no residual beats.
REQ-035 Index 1953125 with macro -> err=1 for exactly one cycle, no out_valid; without macro -> nine zero digits.
REQ-036 Back-to-back: in_valid held high with index 7 then 8 -> second accept only after the first path's out_last transfer; digit streams ...1,2 then ...1,3.
